// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ecc_pkg
// Brief   : Shared width, sequencer state encoding and operand slot codes.
// Revision: 1.0 - initial release
// ============================================================================
package ecc_pkg;

    localparam int ECC_WIDTH = 163;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR     = 3'd4
    } seq_state_t;

    localparam logic [1:0] SLOT_X = 2'd0;
    localparam logic [1:0] SLOT_Y = 2'd1;
    localparam logic [1:0] SLOT_K = 2'd2;
    localparam logic [1:0] SLOT_B = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ecc_load_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : ecc_load_sequencer_if
// Brief   : Sequencer <-> ECC core bus (enable, operand stream, results).
// Revision: 1.0 - initial release
// ============================================================================
interface ecc_load_sequencer_if
    import ecc_pkg::*;
#(
    parameter int WIDTH = ECC_WIDTH
);
    logic             core_enable;
    logic [WIDTH-1:0] core_din;
    logic             core_done;
    logic [WIDTH-1:0] core_dx;
    logic [WIDTH-1:0] core_dy;

    modport master (
        output core_enable,
        output core_din,
        input  core_done,
        input  core_dx,
        input  core_dy
    );

    modport slave (
        input  core_enable,
        input  core_din,
        output core_done,
        output core_dx,
        output core_dy
    );
endinterface
`default_nettype wire

// File: rtl/ecc_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : ecc_watchdog
// Brief   : Compute-phase cycle counter; flags the last permitted cycle.
// Revision: 1.0 - initial release
// ============================================================================
module ecc_watchdog #(
    parameter int TIMEOUT = 1000000,
    parameter int CNT_W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = count_en && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/ecc_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ecc_load_sequencer
// Brief   : Snapshots X/Y/K/B, streams them to the ECC core, supervises the
//           computation with a watchdog and returns DX/DY via done/ack.
// Revision: 1.0 - initial release
// ============================================================================
module ecc_load_sequencer
    import ecc_pkg::*;
#(
    parameter int WIDTH   = ECC_WIDTH,
    parameter int TIMEOUT = 1000000,
    parameter int CNT_W   = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   ack,
    input  logic [WIDTH-1:0]       op_x,
    input  logic [WIDTH-1:0]       op_y,
    input  logic [WIDTH-1:0]       op_k,
    input  logic [WIDTH-1:0]       op_b,
    ecc_load_sequencer_if.master   core,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic [WIDTH-1:0]       res_dx,
    output logic [WIDTH-1:0]       res_dy
);

    seq_state_t       r_state;
    logic [1:0]       r_slot;
    logic [WIDTH-1:0] r_op_x;
    logic [WIDTH-1:0] r_op_y;
    logic [WIDTH-1:0] r_op_k;
    logic [WIDTH-1:0] r_op_b;
    logic             r_core_enable;
    logic [WIDTH-1:0] r_core_din;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout_err;
    logic [WIDTH-1:0] r_res_dx;
    logic [WIDTH-1:0] r_res_dy;

    logic             w_wd_clear;
    logic             w_wd_count;
    logic             w_expired;
    logic [WIDTH-1:0] w_next_operand;

    assign w_wd_count = (r_state == ST_COMPUTE);
    assign w_wd_clear = abort || (r_state != ST_COMPUTE);

    ecc_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_wd_clear),
        .count_en (w_wd_count),
        .expired  (w_expired)
    );

    // core_din is registered, so the mux picks the operand for the slot after the current one.
    always_comb begin
        w_next_operand = r_op_b;
        case (r_slot)
            SLOT_X:  w_next_operand = r_op_y;
            SLOT_Y:  w_next_operand = r_op_k;
            default: w_next_operand = r_op_b;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_slot        <= SLOT_X;
            r_op_x        <= '0;
            r_op_y        <= '0;
            r_op_k        <= '0;
            r_op_b        <= '0;
            r_core_enable <= 1'b0;
            r_core_din    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_res_dx      <= '0;
            r_res_dy      <= '0;
        end else if (abort) begin
            r_state       <= ST_IDLE;
            r_slot        <= SLOT_X;
            r_core_enable <= 1'b0;
            r_core_din    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op_x        <= op_x;
                        r_op_y        <= op_y;
                        r_op_k        <= op_k;
                        r_op_b        <= op_b;
                        r_core_din    <= op_x;
                        r_core_enable <= 1'b1;
                        r_busy        <= 1'b1;
                        r_slot        <= SLOT_X;
                        r_state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (r_slot == SLOT_B) begin
                        r_state <= ST_COMPUTE;
                    end else begin
                        r_slot     <= r_slot + 2'd1;
                        r_core_din <= w_next_operand;
                    end
                end
                ST_COMPUTE: begin
                    // A completion on the watchdog's last cycle still counts as success.
                    if (core.core_done) begin
                        r_res_dx      <= core.core_dx;
                        r_res_dy      <= core.core_dy;
                        r_done        <= 1'b1;
                        r_core_enable <= 1'b0;
                        r_core_din    <= '0;
                        r_busy        <= 1'b0;
                        r_state       <= ST_DONE;
                    end else if (w_expired) begin
                        r_timeout_err <= 1'b1;
                        r_core_enable <= 1'b0;
                        r_core_din    <= '0;
                        r_busy        <= 1'b0;
                        r_state       <= ST_ERR;
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (ack) begin
                        r_timeout_err <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_core_enable <= 1'b0;
                    r_core_din    <= '0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                    r_timeout_err <= 1'b0;
                end
            endcase
        end
    end

    assign core.core_enable = r_core_enable;
    assign core.core_din    = r_core_din;
    assign busy             = r_busy;
    assign done             = r_done;
    assign timeout_err      = r_timeout_err;
    assign res_dx           = r_res_dx;
    assign res_dy           = r_res_dy;

endmodule
`default_nettype wire
